ahb_split_ctrl: RTL and testbench
=================================

# ahb_split_ctrl

AHB slave-side split controller placed in front of one shared, variable-latency resource (e.g. slow memory or peripheral bridge). It answers non-locked transfers with a two-cycle SPLIT response, issues the transfer to the resource, buffers the result and signals the arbiter via HSPLITx, then completes the retried transfer with zero wait states. One transfer is outstanding at a time. Other masters arriving while it is busy are split and released in a batch.

## Interface
- ADDR_W, 32, address width presented to resource
- DATA_W, 32, data width of HWDATA/HRDATA/resource
- HCLK  in  1  bus clock, all logic rising-edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL, HWRITE, HREADY, HMASTLOCK  in  1 each  standard AHB slave inputs
- HTRANS  in  2  transfer type
- HADDR  in  ADDR_W  address
- HWDATA  in  DATA_W  write data (data phase)
- HMASTER  in  4  current master number from arbiter
- HREADYOUT  out  1  slave ready
- HRESP  out  2  OKAY=00, ERROR=01, RETRY=10, SPLIT=11
- HRDATA  out  DATA_W  read data
- HSPLITx  out  16  one-hot-per-master split release to arbiter
- req_valid  out  1  resource request; held until req_ready
- req_write  out  1  request direction
- req_addr  out  ADDR_W  request address
- req_wdata  out  DATA_W  request write data
- req_ready  in  1  resource accepts request
- rsp_valid  in  1  one-cycle completion pulse
- rsp_rdata  in  DATA_W  read data, valid with rsp_valid

## Operation
- Address phase accepted when HSEL && HREADY && HTRANS[1] (NONSEQ/SEQ). Latch HADDR, HWRITE, HMASTER, HMASTLOCK. IDLE/BUSY transfers get zero-wait OKAY.
- FSM states: IDLE, SPLIT1, SPLIT2, ISSUE, WAIT_RSP, DONE, LOCK_WAIT, ERR1, ERR2.
- IDLE + accepted non-locked transfer -> SPLIT1. Record owner = HMASTER, capture addr/dir.
- SPLIT1 (HREADYOUT=0, HRESP=SPLIT): capture HWDATA if write -> SPLIT2.
- SPLIT2 (HREADYOUT=1, HRESP=SPLIT) -> ISSUE.
- ISSUE: req_valid=1 until req_ready -> WAIT_RSP.
- WAIT_RSP: on rsp_valid, buffer rsp_rdata -> DONE. Pulse HSPLITx[owner] for one cycle.
- DONE: owner retry matching addr and dir -> zero-wait OKAY with HRDATA=buffer, then IDLE. Owner retry with mismatching addr/dir -> ERR1/ERR2 (two-cycle ERROR), then IDLE.
- Accepted locked transfer (HMASTLOCK=1) in IDLE -> LOCK_WAIT. Never split. HREADYOUT=0 while the request is issued and the response awaited. On rsp_valid, HREADYOUT=1, OKAY, HRDATA=rsp_rdata.
- Transfer from any non-owner master while not IDLE: two-cycle SPLIT, set wait_mask[HMASTER], no request. Non-owner locked transfer while busy: two-cycle RETRY instead.
- On exit from DONE or ERR2 to IDLE: HSPLITx = wait_mask for one cycle, then wait_mask cleared. A bit set in that same cycle is kept for the next release.

## Timing
- Reset values: HREADYOUT=1, HRESP=OKAY, HRDATA=0, HSPLITx=0, req_valid=0, req_* =0, wait_mask=0, state IDLE.
- SPLIT/RETRY/ERROR: exactly two data-phase cycles, first with HREADYOUT=0, second with HREADYOUT=1.
- Resource to arbiter latency: HSPLITx[owner] asserted the cycle after rsp_valid.
- Retry hit: OKAY in first data-phase cycle, zero wait.
- req_* stable while req_valid && !req_ready.
- rsp_valid outside WAIT_RSP/LOCK_WAIT is ignored.
- HRESET mid-operation: immediate return to reset values. Pending owner and wait_mask are lost, and no HSPLITx is issued.

## Structure
- Shared package ahb_pkg: htrans_t (IDLE/BUSY/NONSEQ/SEQ), hresp_t constants, split_state_t enum.
- Sub-module ahb_split_mask: 16-bit wait mask with set/release/clear-on-release logic and HSPLITx generation.

## Test plan
- Read 0x100 by master 2, resource latency 5 -> SPLIT (0,1 HREADYOUT), req_addr=0x100, HSPLITx=0x0004 one cycle after rsp_valid, retry returns OKAY with rsp_rdata, zero wait.
- Write 0x40 data 0xDEADBEEF by master 1 -> req_wdata=0xDEADBEEF, req_write=1, retry gives OKAY.
- Master 2 owns, masters 3 and 5 arrive -> both split, no requests. After owner completes, HSPLITx=0x0028 one cycle.
- Locked read by master 4 -> no SPLIT, HREADYOUT low until rsp_valid, OKAY same cycle.
- Owner retries with 0x104 instead of 0x100 -> two-cycle ERROR, state IDLE, wait_mask released.
- HRESET asserted in WAIT_RSP -> all outputs at reset values next edge, later rsp_valid ignored, HSPLITx stays 0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB types for the split controller: transfer/response codes,
// controller FSM states and the master-number helper.
package ahb_pkg;

   localparam int MID_W   = 4;
   localparam int NUM_MST = 16;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [1:0] HRESP_RETRY = 2'b10;
   localparam logic [1:0] HRESP_SPLIT = 2'b11;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SPLIT1,
      ST_SPLIT2,
      ST_ISSUE,
      ST_WAIT_RSP,
      ST_DONE,
      ST_LOCK_WAIT,
      ST_ERR1,
      ST_ERR2
   } split_state_t;

   // Locked transfers: grab write data, present the request, await the response.
   typedef enum logic [1:0] {
      LK_CAPTURE,
      LK_REQUEST,
      LK_AWAIT
   } lock_phase_t;

   // Two-cycle responses given to masters that arrive while the resource is busy.
   typedef enum logic [1:0] {
      SIDE_NONE,
      SIDE_FIRST,
      SIDE_SECOND
   } side_phase_t;

   function automatic logic [NUM_MST-1:0] master_bit(input logic [MID_W-1:0] id);
      logic [NUM_MST-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/ahb_split_mask.sv
// Wait mask of split masters plus registered HSPLITx generation
// (single owner release or whole-mask batch release).
module ahb_split_mask
   import ahb_pkg::*;
(
   input  logic               HCLK,
   input  logic               HRESET,
   input  logic               set_en,
   input  logic [MID_W-1:0]   set_id,
   input  logic               owner_rel,
   input  logic [MID_W-1:0]   owner_id,
   input  logic               mask_rel,
   output logic [NUM_MST-1:0] HSPLITx
);

   logic [NUM_MST-1:0] mask_reg;
   logic [NUM_MST-1:0] mask_next;
   logic [NUM_MST-1:0] hsplit_reg;
   logic [NUM_MST-1:0] hsplit_next;
   logic [NUM_MST-1:0] set_vec;
   logic [NUM_MST-1:0] owner_vec;

   assign set_vec   = set_en    ? master_bit(set_id)   : '0;
   assign owner_vec = owner_rel ? master_bit(owner_id) : '0;

   // A bit set in the release cycle survives into the next batch.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_MST; gi++) begin : g_bit
         assign mask_next[gi]   = set_vec[gi] | (mask_reg[gi] & ~mask_rel);
         assign hsplit_next[gi] = owner_vec[gi] | (mask_reg[gi] & mask_rel);
      end
   endgenerate

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         mask_reg   <= '0;
         hsplit_reg <= '0;
      end else begin
         mask_reg   <= mask_next;
         hsplit_reg <= hsplit_next;
      end
   end

   assign HSPLITx = hsplit_reg;

endmodule

// File: rtl/ahb_split_ctrl.sv
// AHB split controller in front of one variable-latency resource: splits
// the requester, runs the access, then serves the retry from a buffer.
module ahb_split_ctrl
   import ahb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)
(
   input  logic               HCLK,
   input  logic               HRESET,
   input  logic               HSEL,
   input  logic               HWRITE,
   input  logic               HREADY,
   input  logic               HMASTLOCK,
   input  logic [1:0]         HTRANS,
   input  logic [ADDR_W-1:0]  HADDR,
   input  logic [DATA_W-1:0]  HWDATA,
   input  logic [MID_W-1:0]   HMASTER,
   output logic               HREADYOUT,
   output logic [1:0]         HRESP,
   output logic [DATA_W-1:0]  HRDATA,
   output logic [NUM_MST-1:0] HSPLITx,
   output logic               req_valid,
   output logic               req_write,
   output logic [ADDR_W-1:0]  req_addr,
   output logic [DATA_W-1:0]  req_wdata,
   input  logic               req_ready,
   input  logic               rsp_valid,
   input  logic [DATA_W-1:0]  rsp_rdata
);

   split_state_t      state_reg, state_next;
   lock_phase_t       lock_reg, lock_next;
   side_phase_t       side_reg, side_next;
   logic [1:0]        side_resp_reg, side_resp_next;
   logic [MID_W-1:0]  owner_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic              write_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] rdata_reg;

   htrans_t htrans;
   logic    accept;
   logic    is_owner;
   logic    addr_hit;
   logic    capture_addr;
   logic    mask_set;
   logic    owner_rel;
   logic    mask_rel;

   assign htrans   = htrans_t'(HTRANS);
   assign accept   = HSEL && HREADY && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
   assign is_owner = (HMASTER == owner_reg);
   assign addr_hit = (HADDR == addr_reg) && (HWRITE == write_reg);

   always_comb begin
      state_next     = state_reg;
      lock_next      = lock_reg;
      side_next      = side_reg;
      side_resp_next = side_resp_reg;
      capture_addr   = 1'b0;
      mask_set       = 1'b0;
      owner_rel      = 1'b0;
      mask_rel       = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               capture_addr = 1'b1;
               if (HMASTLOCK) begin
                  state_next = ST_LOCK_WAIT;
                  lock_next  = LK_CAPTURE;
               end else begin
                  state_next = ST_SPLIT1;
               end
            end
         end
         ST_SPLIT1:   state_next = ST_SPLIT2;
         ST_SPLIT2:   state_next = ST_ISSUE;
         ST_ISSUE:    if (req_ready) state_next = ST_WAIT_RSP;
         ST_WAIT_RSP: begin
            if (rsp_valid) begin
               state_next = ST_DONE;
               owner_rel  = 1'b1;
            end
         end
         ST_DONE: begin
            if (accept && is_owner) begin
               if (addr_hit) begin
                  state_next = ST_IDLE;
                  mask_rel   = 1'b1;
               end else begin
                  state_next = ST_ERR1;
               end
            end
         end
         ST_ERR1: state_next = ST_ERR2;
         ST_ERR2: begin
            state_next = ST_IDLE;
            mask_rel   = 1'b1;
         end
         ST_LOCK_WAIT: begin
            case (lock_reg)
               LK_CAPTURE: lock_next = LK_REQUEST;
               LK_REQUEST: if (req_ready) lock_next = LK_AWAIT;
               default:    if (rsp_valid) state_next = ST_IDLE;
            endcase
         end
         default: state_next = ST_IDLE;
      endcase

      case (side_reg)
         SIDE_FIRST:  side_next = SIDE_SECOND;
         SIDE_SECOND: side_next = SIDE_NONE;
         default:     ;
      endcase

      // Anyone but the owner-in-DONE is turned away while the resource is busy.
      if (accept && state_reg != ST_IDLE && !(state_reg == ST_DONE && is_owner)) begin
         side_next = SIDE_FIRST;
         if (HMASTLOCK && !is_owner) begin
            side_resp_next = HRESP_RETRY;
         end else begin
            side_resp_next = HRESP_SPLIT;
            mask_set       = 1'b1;
         end
      end
   end

   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      case (state_reg)
         ST_SPLIT1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_SPLIT;
         end
         ST_SPLIT2:    HRESP = HRESP_SPLIT;
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
         end
         ST_ERR2:      HRESP = HRESP_ERROR;
         ST_LOCK_WAIT: HREADYOUT = (lock_reg == LK_AWAIT) && rsp_valid;
         default:      ;
      endcase
      if (side_reg == SIDE_FIRST) begin
         HREADYOUT = 1'b0;
         HRESP     = side_resp_reg;
      end else if (side_reg == SIDE_SECOND) begin
         HREADYOUT = 1'b1;
         HRESP     = side_resp_reg;
      end
   end

   assign HRDATA    = (state_reg == ST_LOCK_WAIT) ? rsp_rdata : rdata_reg;
   assign req_valid = (state_reg == ST_ISSUE) ||
                      (state_reg == ST_LOCK_WAIT && lock_reg == LK_REQUEST);
   assign req_write = write_reg;
   assign req_addr  = addr_reg;
   assign req_wdata = wdata_reg;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_reg     <= ST_IDLE;
         lock_reg      <= LK_CAPTURE;
         side_reg      <= SIDE_NONE;
         side_resp_reg <= HRESP_OKAY;
         owner_reg     <= '0;
         addr_reg      <= '0;
         write_reg     <= 1'b0;
         wdata_reg     <= '0;
         rdata_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         lock_reg      <= lock_next;
         side_reg      <= side_next;
         side_resp_reg <= side_resp_next;
         if (capture_addr) begin
            owner_reg <= HMASTER;
            addr_reg  <= HADDR;
            write_reg <= HWRITE;
         end
         // Write data is in its data phase during SPLIT1 or the first locked cycle.
         if (write_reg && (state_reg == ST_SPLIT1 ||
                           (state_reg == ST_LOCK_WAIT && lock_reg == LK_CAPTURE)))
            wdata_reg <= HWDATA;
         if (state_reg == ST_WAIT_RSP && rsp_valid)
            rdata_reg <= rsp_rdata;
      end
   end

   ahb_split_mask u_mask (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .set_en    (mask_set),
      .set_id    (HMASTER),
      .owner_rel (owner_rel),
      .owner_id  (owner_reg),
      .mask_rel  (mask_rel),
      .HSPLITx   (HSPLITx)
   );

endmodule

// File: tb/tb_ahb_split_ctrl.sv
// Directed bench for ahb_split_ctrl: single-slave bus (HREADY = HREADYOUT),
// hand-computed expectations for each transfer scenario.
module tb_ahb_split_ctrl;

   logic        HCLK;
   logic        HRESET;
   logic        HSEL;
   logic        HWRITE;
   logic        HREADY;
   logic        HMASTLOCK;
   logic [1:0]  HTRANS;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic [3:0]  HMASTER;
   logic        HREADYOUT;
   logic [1:0]  HRESP;
   logic [31:0] HRDATA;
   logic [15:0] HSPLITx;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;

   int vec_cnt = 0;
   int err_cnt = 0;

   ahb_split_ctrl dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .HSEL      (HSEL),
      .HWRITE    (HWRITE),
      .HREADY    (HREADY),
      .HMASTLOCK (HMASTLOCK),
      .HTRANS    (HTRANS),
      .HADDR     (HADDR),
      .HWDATA    (HWDATA),
      .HMASTER   (HMASTER),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .HSPLITx   (HSPLITx),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata)
   );

   assign HREADY = HREADYOUT;

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   // Address phase in the current cycle; returns one cycle later in the data phase.
   task automatic start_xfer(input logic [3:0] m, input logic [31:0] a,
                             input logic w, input logic lk);
      HSEL      = 1'b1;
      HTRANS    = 2'b10;
      HMASTER   = m;
      HADDR     = a;
      HWRITE    = w;
      HMASTLOCK = lk;
      cyc();
      HSEL      = 1'b0;
      HTRANS    = 2'b00;
      HMASTLOCK = 1'b0;
   endtask

   // Split transfer with immediate req_ready and one-cycle latency; returns in DONE.
   task automatic split_to_done(input logic [3:0] m, input logic [31:0] a, input logic w,
                                input logic [31:0] wd, input logic [31:0] rd);
      logic [15:0] exp_bit;
      exp_bit = 16'h0001 << m;
      start_xfer(m, a, w, 1'b0);
      HWDATA = wd;
      #2;
      check("std_split1_resp", 32'(HRESP), 32'd3);
      cyc();
      HWDATA = '0;
      cyc();
      req_ready = 1'b1;
      #2;
      check("std_req_addr", req_addr, a);
      check("std_req_write", 32'(req_write), 32'(w));
      if (w) check("std_req_wdata", req_wdata, wd);
      cyc();
      req_ready = 1'b0;
      rsp_valid = 1'b1;
      rsp_rdata = rd;
      cyc();
      rsp_valid = 1'b0;
      #2;
      check("std_owner_hsplit", 32'(HSPLITx), 32'(exp_bit));
   endtask

   initial begin
      HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HMASTLOCK = 1'b0;
      HADDR = '0; HWDATA = '0; HMASTER = '0;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;

      // Reset values
      repeat (2) cyc();
      #2;
      check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
      check("rst_hresp", 32'(HRESP), 32'd0);
      check("rst_hrdata", HRDATA, 32'd0);
      check("rst_hsplit", 32'(HSPLITx), 32'd0);
      check("rst_req_valid", 32'(req_valid), 32'd0);
      HRESET = 1'b0;
      cyc();

      // BUSY transfer: zero-wait OKAY, no request
      HSEL = 1'b1; HTRANS = 2'b01; HMASTER = 4'd3; HADDR = 32'h10;
      cyc();
      HSEL = 1'b0; HTRANS = 2'b00;
      #2;
      check("busy_rdy", 32'(HREADYOUT), 32'd1);
      check("busy_resp", 32'(HRESP), 32'd0);
      check("busy_noreq", 32'(req_valid), 32'd0);

      // Master 2 reads 0x100, resource latency 5
      start_xfer(4'd2, 32'h100, 1'b0, 1'b0);
      #2;
      check("t1_split1_rdy", 32'(HREADYOUT), 32'd0);
      check("t1_split1_resp", 32'(HRESP), 32'd3);
      cyc(); #2;
      check("t1_split2_rdy", 32'(HREADYOUT), 32'd1);
      check("t1_split2_resp", 32'(HRESP), 32'd3);
      cyc(); #2;
      check("t1_req_valid", 32'(req_valid), 32'd1);
      check("t1_req_addr", req_addr, 32'h100);
      check("t1_req_write", 32'(req_write), 32'd0);
      cyc();
      req_ready = 1'b1;
      #2;
      check("t1_req_hold_valid", 32'(req_valid), 32'd1);
      check("t1_req_hold_addr", req_addr, 32'h100);
      cyc();
      req_ready = 1'b0;
      #2;
      check("t1_req_drop", 32'(req_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(); #2;
         check("t1_wait_hsplit", 32'(HSPLITx), 32'd0);
      end
      cyc();
      rsp_valid = 1'b1; rsp_rdata = 32'hCAFE0100;
      #2;
      check("t1_rsp_cycle_hsplit", 32'(HSPLITx), 32'd0);
      cyc();
      rsp_valid = 1'b0;
      #2;
      check("t1_hsplit_owner", 32'(HSPLITx), 32'h0004);
      cyc(); #2;
      check("t1_hsplit_pulse", 32'(HSPLITx), 32'd0);
      start_xfer(4'd2, 32'h100, 1'b0, 1'b0);
      #2;
      check("t1_retry_rdy", 32'(HREADYOUT), 32'd1);
      check("t1_retry_resp", 32'(HRESP), 32'd0);
      check("t1_retry_rdata", HRDATA, 32'hCAFE0100);

      // Master 1 writes 0xDEADBEEF to 0x40
      split_to_done(4'd1, 32'h40, 1'b1, 32'hDEADBEEF, 32'h0);
      start_xfer(4'd1, 32'h40, 1'b1, 1'b0);
      #2;
      check("t2_retry_rdy", 32'(HREADYOUT), 32'd1);
      check("t2_retry_resp", 32'(HRESP), 32'd0);

      // Master 2 owns; masters 3 and 5 are split while it is busy
      start_xfer(4'd2, 32'h200, 1'b0, 1'b0);
      cyc();
      cyc();
      start_xfer(4'd3, 32'h300, 1'b0, 1'b0);
      #2;
      check("t3_m3_rdy", 32'(HREADYOUT), 32'd0);
      check("t3_m3_resp", 32'(HRESP), 32'd3);
      check("t3_req_addr", req_addr, 32'h200);
      cyc(); #2;
      check("t3_m3_rdy2", 32'(HREADYOUT), 32'd1);
      check("t3_m3_resp2", 32'(HRESP), 32'd3);
      start_xfer(4'd5, 32'h500, 1'b0, 1'b0);
      #2;
      check("t3_m5_resp", 32'(HRESP), 32'd3);
      check("t3_req_addr2", req_addr, 32'h200);
      cyc();
      req_ready = 1'b1;
      #2;
      check("t3_m5_rdy2", 32'(HREADYOUT), 32'd1);
      cyc();
      req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'h11112222;
      cyc();
      rsp_valid = 1'b0;
      #2;
      check("t3_hsplit_owner", 32'(HSPLITx), 32'h0004);
      start_xfer(4'd2, 32'h200, 1'b0, 1'b0);
      #2;
      check("t3_retry_rdata", HRDATA, 32'h11112222);
      check("t3_hsplit_batch", 32'(HSPLITx), 32'h0028);
      cyc(); #2;
      check("t3_hsplit_clear", 32'(HSPLITx), 32'd0);

      // Locked read by master 4: no split, waits until rsp_valid
      start_xfer(4'd4, 32'h80, 1'b0, 1'b1);
      #2;
      check("t4_cap_rdy", 32'(HREADYOUT), 32'd0);
      check("t4_cap_noreq", 32'(req_valid), 32'd0);
      cyc();
      req_ready = 1'b1;
      #2;
      check("t4_req_valid", 32'(req_valid), 32'd1);
      check("t4_req_addr", req_addr, 32'h80);
      check("t4_req_rdy", 32'(HREADYOUT), 32'd0);
      cyc();
      req_ready = 1'b0;
      #2;
      check("t4_await_rdy", 32'(HREADYOUT), 32'd0);
      check("t4_await_noreq", 32'(req_valid), 32'd0);
      cyc();
      rsp_valid = 1'b1; rsp_rdata = 32'h4444AAAA;
      #2;
      check("t4_done_rdy", 32'(HREADYOUT), 32'd1);
      check("t4_done_resp", 32'(HRESP), 32'd0);
      check("t4_done_rdata", HRDATA, 32'h4444AAAA);
      cyc();
      rsp_valid = 1'b0;
      #2;
      check("t4_no_hsplit", 32'(HSPLITx), 32'd0);

      // Owner retries 0x104 instead of 0x100 -> two-cycle ERROR, mask released
      split_to_done(4'd2, 32'h100, 1'b0, 32'h0, 32'h5555AAAA);
      start_xfer(4'd6, 32'h600, 1'b0, 1'b0);
      #2;
      check("t5_m6_resp", 32'(HRESP), 32'd3);
      cyc();
      start_xfer(4'd2, 32'h104, 1'b0, 1'b0);
      #2;
      check("t5_err1_rdy", 32'(HREADYOUT), 32'd0);
      check("t5_err1_resp", 32'(HRESP), 32'd1);
      cyc(); #2;
      check("t5_err2_rdy", 32'(HREADYOUT), 32'd1);
      check("t5_err2_resp", 32'(HRESP), 32'd1);
      cyc(); #2;
      check("t5_hsplit_mask", 32'(HSPLITx), 32'h0040);
      check("t5_idle_resp", 32'(HRESP), 32'd0);
      cyc(); #2;
      check("t5_hsplit_clear", 32'(HSPLITx), 32'd0);

      // New owner proves IDLE; reset in WAIT_RSP with master 9 pending
      start_xfer(4'd7, 32'h700, 1'b0, 1'b0);
      cyc();
      cyc(); #2;
      check("t6_req_valid", 32'(req_valid), 32'd1);
      check("t6_req_addr", req_addr, 32'h700);
      start_xfer(4'd9, 32'h900, 1'b0, 1'b0);
      cyc();
      req_ready = 1'b1;
      cyc();
      req_ready = 1'b0;
      HRESET = 1'b1;
      #2;
      check("t6_rst_rdy", 32'(HREADYOUT), 32'd1);
      check("t6_rst_resp", 32'(HRESP), 32'd0);
      check("t6_rst_rdata", HRDATA, 32'd0);
      check("t6_rst_req_addr", req_addr, 32'd0);
      check("t6_rst_req_wdata", req_wdata, 32'd0);
      cyc();
      HRESET = 1'b0;
      rsp_valid = 1'b1; rsp_rdata = 32'h00000BAD;
      cyc();
      rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         check("t6_hsplit_quiet", 32'(HSPLITx), 32'd0);
         check("t6_rdata_quiet", HRDATA, 32'd0);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
